// File: rtl/sdr_tx_scheduler.sv
// sdr_tx_scheduler: single-grant arbiter for the protocol-2 UDP transmit path.
// CC always wins, DDC ports are served round-robin, wideband continuation
// packets wait for a full DDC round, and a starvation counter promotes DDC
// traffic after a run of MIC/WB grants.
module sdr_tx_scheduler #(
  parameter int NR           = 8,
  parameter int STARVE_LIMIT = 8
) (
  input  logic          tx_clock,
  input  logic          reset_n,
  input  logic          run,
  input  logic          wideband,
  input  logic [7:0]    wb_packets_per_frame,
  input  logic          cc_ready,
  input  logic          mic_ready,
  input  logic          sp_data_ready,
  input  logic [NR-1:0] fifo_ready,
  input  logic          grant_ack,
  input  logic          pkt_done,
  output logic          grant_valid,
  output logic [1:0]    grant_src,
  output logic [3:0]    grant_ddc,
  output logic [7:0]    port_ID,
  output logic          wb_frame_start,
  output logic          busy
);

  localparam logic [1:0] SRC_CC  = 2'd0;
  localparam logic [1:0] SRC_MIC = 2'd1;
  localparam logic [1:0] SRC_WB  = 2'd2;
  localparam logic [1:0] SRC_DDC = 2'd3;

  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);
  localparam logic [3:0] LAST_DDC   = 4'(NR - 1);
  localparam logic [4:0] NR_W       = 5'(NR);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARB,
    S_GRANT,
    S_WAIT_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [3:0] r_rr_ptr;
  logic [7:0] r_wb_count;
  logic       r_ddc_round_done;
  logic [7:0] r_starve_cnt;
  logic [1:0] r_grant_src;
  logic [3:0] r_grant_ddc;
  logic [7:0] r_port_id;
  logic       r_wb_frame_start;

  logic            w_any_ddc;
  logic            w_starved;
  logic            w_wb_ok;
  logic [7:0]      w_ppf_last;
  logic [7:0]      w_starve_step;
  logic [2*NR-1:0] w_dbl;
  logic [NR-1:0]   w_rot;
  logic [4:0]      w_off;
  logic [4:0]      w_sum;
  logic [3:0]      w_rr_idx;
  logic            w_win;
  logic [1:0]      w_win_src;
  logic [7:0]      w_win_port;

  assign w_any_ddc  = |fifo_ready;
  assign w_starved  = (r_starve_cnt == STARVE_MAX);
  assign w_wb_ok    = wideband & sp_data_ready & ((r_wb_count == 8'd0) | r_ddc_round_done);
  // A frame length of 0 behaves like 1, so the last packet index is 0 then.
  assign w_ppf_last = (wb_packets_per_frame == 8'd0) ? 8'd0 : wb_packets_per_frame - 8'd1;
  // Only count toward starvation while some DDC port is actually waiting.
  assign w_starve_step = !w_any_ddc ? 8'd0 :
                         w_starved  ? STARVE_MAX : r_starve_cnt + 8'd1;

  // Rotate the request vector so bit k is port (rr_ptr + k) mod NR.
  assign w_dbl = {fifo_ready, fifo_ready} >> r_rr_ptr;
  assign w_rot = w_dbl[NR-1:0];

  // Round-robin search: lowest rotated offset wins, then map back to a port index.
  always_comb begin
    w_off = 5'd0;
    for (int k = NR - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off = 5'(k);
      end
    end
    w_sum    = {1'b0, r_rr_ptr} + w_off;
    w_rr_idx = (w_sum >= NR_W) ? 4'(w_sum - NR_W) : w_sum[3:0];
  end

  // Next-state and arbitration decision in fixed priority order.
  always_comb begin
    w_state_next = r_state;
    w_win        = 1'b0;
    w_win_src    = SRC_CC;
    case (r_state)
      S_IDLE: begin
        if (run) w_state_next = S_ARB;
      end
      S_ARB: begin
        if (cc_ready) begin
          w_win     = 1'b1;
          w_win_src = SRC_CC;
        end else if (w_any_ddc && w_starved) begin
          w_win     = 1'b1;
          w_win_src = SRC_DDC;
        end else if (mic_ready) begin
          w_win     = 1'b1;
          w_win_src = SRC_MIC;
        end else if (w_wb_ok) begin
          w_win     = 1'b1;
          w_win_src = SRC_WB;
        end else if (w_any_ddc) begin
          w_win     = 1'b1;
          w_win_src = SRC_DDC;
        end
        if (w_win) w_state_next = S_GRANT;
      end
      S_GRANT: begin
        // pkt_done is meaningless until the sender has taken the grant.
        if (grant_ack) w_state_next = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (pkt_done) w_state_next = S_ARB;
      end
      default: w_state_next = S_IDLE;
    endcase
    if (!run) w_state_next = S_IDLE;
  end

  // Port number for the winning source.
  always_comb begin
    w_win_port = 8'd0;
    case (w_win_src)
      SRC_CC:  w_win_port = 8'd1;
      SRC_MIC: w_win_port = 8'd2;
      SRC_WB:  w_win_port = 8'd3;
      default: w_win_port = 8'd11 + {4'd0, w_rr_idx};
    endcase
  end

  // State register.
  always_ff @(posedge tx_clock) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Grant fields and fairness bookkeeping; dropping run aborts and wipes history.
  always_ff @(posedge tx_clock) begin
    if (!reset_n || !run) begin
      r_rr_ptr         <= 4'd0;
      r_wb_count       <= 8'd0;
      r_ddc_round_done <= 1'b0;
      r_starve_cnt     <= 8'd0;
      r_grant_src      <= 2'd0;
      r_grant_ddc      <= 4'd0;
      r_port_id        <= 8'd0;
      r_wb_frame_start <= 1'b0;
    end else begin
      r_wb_frame_start <= 1'b0;
      case (r_state)
        S_ARB: begin
          if (!wideband) begin
            r_wb_count       <= 8'd0;
            r_ddc_round_done <= 1'b0;
          end
          if (w_win) begin
            r_grant_src <= w_win_src;
            r_grant_ddc <= (w_win_src == SRC_DDC) ? w_rr_idx : 4'd0;
            r_port_id   <= w_win_port;
          end
        end
        S_GRANT: begin
          if (grant_ack) begin
            case (r_grant_src)
              SRC_DDC: begin
                r_rr_ptr     <= (r_grant_ddc == LAST_DDC) ? 4'd0 : r_grant_ddc + 4'd1;
                r_starve_cnt <= 8'd0;
                if ((r_grant_ddc == LAST_DDC) || (r_grant_ddc < r_rr_ptr)) begin
                  r_ddc_round_done <= 1'b1;
                end
              end
              SRC_MIC: begin
                r_starve_cnt <= w_starve_step;
              end
              SRC_WB: begin
                r_starve_cnt     <= w_starve_step;
                r_ddc_round_done <= 1'b0;
                if (r_wb_count == 8'd0) r_wb_frame_start <= 1'b1;
                // >= so a shrunken frame length wraps a count that is already past it.
                r_wb_count <= (r_wb_count >= w_ppf_last) ? 8'd0 : r_wb_count + 8'd1;
              end
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  assign grant_valid    = (r_state == S_GRANT);
  assign busy           = (r_state == S_GRANT) || (r_state == S_WAIT_DONE);
  assign grant_src      = r_grant_src;
  assign grant_ddc      = r_grant_ddc;
  assign port_ID        = r_port_id;
  assign wb_frame_start = r_wb_frame_start;

endmodule

// File: tb/tb_sdr_tx_scheduler.sv
// Bench for sdr_tx_scheduler: table of grant transactions checked through a
// scoreboard queue, plus hand-written reset, abort and handshake sequences.
module tb_sdr_tx_scheduler;

  localparam int NR = 8;

  logic          tx_clock = 1'b0;
  logic          reset_n;
  logic          run;
  logic          wideband;
  logic [7:0]    wb_packets_per_frame;
  logic          cc_ready;
  logic          mic_ready;
  logic          sp_data_ready;
  logic [NR-1:0] fifo_ready;
  logic          grant_ack;
  logic          pkt_done;
  logic          grant_valid;
  logic [1:0]    grant_src;
  logic [3:0]    grant_ddc;
  logic [7:0]    port_ID;
  logic          wb_frame_start;
  logic          busy;

  sdr_tx_scheduler #(.NR(NR), .STARVE_LIMIT(3)) dut (
    .tx_clock             (tx_clock),
    .reset_n              (reset_n),
    .run                  (run),
    .wideband             (wideband),
    .wb_packets_per_frame (wb_packets_per_frame),
    .cc_ready             (cc_ready),
    .mic_ready            (mic_ready),
    .sp_data_ready        (sp_data_ready),
    .fifo_ready           (fifo_ready),
    .grant_ack            (grant_ack),
    .pkt_done             (pkt_done),
    .grant_valid          (grant_valid),
    .grant_src            (grant_src),
    .grant_ddc            (grant_ddc),
    .port_ID              (port_ID),
    .wb_frame_start       (wb_frame_start),
    .busy                 (busy)
  );

  always #5 tx_clock = ~tx_clock;

  typedef struct {
    bit         rst;
    bit         wb;
    logic [7:0] ppf;
    bit         cc;
    bit         mic;
    bit         sp;
    logic [7:0] fifo;
    logic [1:0] src;
    logic [3:0] ddc;
    logic [7:0] port;
    bit         fs;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   outstanding = 1'b0;

  function automatic vec_t mk(int rst, int wb, int ppf, int cc, int mic, int sp, int fifo,
                              int src, int ddc, int port, int fs);
    vec_t v;
    v.rst  = (rst != 0);
    v.wb   = (wb != 0);
    v.ppf  = 8'(ppf);
    v.cc   = (cc != 0);
    v.mic  = (mic != 0);
    v.sp   = (sp != 0);
    v.fifo = 8'(fifo);
    v.src  = 2'(src);
    v.ddc  = 4'(ddc);
    v.port = 8'(port);
    v.fs   = (fs != 0);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    wideband             = 1'b0;
    wb_packets_per_frame = 8'd0;
    cc_ready             = 1'b0;
    mic_ready            = 1'b0;
    sp_data_ready        = 1'b0;
    fifo_ready           = '0;
    grant_ack            = 1'b0;
    pkt_done             = 1'b0;
  endtask

  // Reset, then leave the DUT idling in ARB with nothing requested.
  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    run     = 1'b0;
    repeat (3) @(negedge tx_clock);
    reset_n = 1'b1;
    run     = 1'b1;
    @(negedge tx_clock);
    outstanding = 1'b0;
  endtask

  task automatic wait_gv(inout int lat);
    while (grant_valid !== 1'b1 && lat < 30) begin
      @(negedge tx_clock);
      lat++;
    end
  endtask

  // One transaction: drive readies, finish the previous packet, take the grant.
  task automatic apply_vec(input vec_t v);
    int   lat;
    vec_t e;
    wideband             = v.wb;
    wb_packets_per_frame = v.ppf;
    cc_ready             = v.cc;
    mic_ready            = v.mic;
    sp_data_ready        = v.sp;
    fifo_ready           = v.fifo;
    exp_q.push_back(v);
    lat = 0;
    if (outstanding) begin
      pkt_done = 1'b1;
      @(negedge tx_clock);
      pkt_done = 1'b0;
      lat = 1;
    end
    wait_gv(lat);
    e = exp_q.pop_front();
    check("grant_timeout", 32'(grant_valid), 32'd1);
    if (grant_valid === 1'b1) begin
      check("grant_src", 32'(grant_src), 32'(e.src));
      check("port_ID", 32'(port_ID), 32'(e.port));
      if (e.src == 2'd3) check("grant_ddc", 32'(grant_ddc), 32'(e.ddc));
      check("busy_in_grant", 32'(busy), 32'd1);
      if (outstanding) check("arb_latency", 32'(lat), 32'd2);
      $display("grant src=%0d ddc=%0d port=%0d lat=%0d", grant_src, grant_ddc, port_ID, lat);
      grant_ack = 1'b1;
      @(negedge tx_clock);
      grant_ack = 1'b0;
      check("gv_after_ack", 32'(grant_valid), 32'd0);
      check("busy_wait_done", 32'(busy), 32'd1);
      check("wb_frame_start", 32'(wb_frame_start), 32'(e.fs));
    end
    outstanding = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;

    // Priority: CC, MIC, WB, then DDC0 as each source is consumed.
    vecs.push_back(mk(1, 1, 4, 1, 1, 1, 'hFF, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 4, 0, 1, 1, 'hFF, 1, 0, 2, 0));
    vecs.push_back(mk(0, 1, 4, 0, 0, 1, 'hFF, 2, 0, 3, 1));
    vecs.push_back(mk(0, 1, 4, 0, 0, 0, 'hFF, 3, 0, 11, 0));
    // Round robin over 1010_0101.
    vecs.push_back(mk(1, 0, 4, 0, 0, 0, 'hA5, 3, 0, 11, 0));
    vecs.push_back(mk(0, 0, 4, 0, 0, 0, 'hA5, 3, 2, 13, 0));
    vecs.push_back(mk(0, 0, 4, 0, 0, 0, 'hA5, 3, 5, 16, 0));
    vecs.push_back(mk(0, 0, 4, 0, 0, 0, 'hA5, 3, 7, 18, 0));
    vecs.push_back(mk(0, 0, 4, 0, 0, 0, 'hA5, 3, 0, 11, 0));
    // Wideband frame of 4 interleaved with DDC0 rounds.
    vecs.push_back(mk(1, 1, 4, 0, 0, 1, 'h01, 2, 0, 3, 1));
    vecs.push_back(mk(0, 1, 4, 0, 0, 1, 'h01, 3, 0, 11, 0));
    vecs.push_back(mk(0, 1, 4, 0, 0, 1, 'h01, 3, 0, 11, 0));
    vecs.push_back(mk(0, 1, 4, 0, 0, 1, 'h01, 2, 0, 3, 0));
    vecs.push_back(mk(0, 1, 4, 0, 0, 1, 'h01, 3, 0, 11, 0));
    vecs.push_back(mk(0, 1, 4, 0, 0, 1, 'h01, 2, 0, 3, 0));
    vecs.push_back(mk(0, 1, 4, 0, 0, 1, 'h01, 3, 0, 11, 0));
    vecs.push_back(mk(0, 1, 4, 0, 0, 1, 'h01, 2, 0, 3, 0));
    vecs.push_back(mk(0, 1, 4, 0, 0, 1, 'h01, 2, 0, 3, 1));
    vecs.push_back(mk(0, 1, 4, 0, 0, 1, 'h01, 3, 0, 11, 0));
    // Starvation guard with limit 3.
    vecs.push_back(mk(1, 0, 4, 0, 1, 0, 'h10, 1, 0, 2, 0));
    vecs.push_back(mk(0, 0, 4, 0, 1, 0, 'h10, 1, 0, 2, 0));
    vecs.push_back(mk(0, 0, 4, 0, 1, 0, 'h10, 1, 0, 2, 0));
    vecs.push_back(mk(0, 0, 4, 0, 1, 0, 'h10, 3, 4, 15, 0));
    vecs.push_back(mk(0, 0, 4, 0, 1, 0, 'h10, 1, 0, 2, 0));
    // Frame length 0 behaves as 1: every WB packet starts a frame.
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 'h00, 2, 0, 3, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 'h00, 2, 0, 3, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 'h00, 2, 0, 3, 1));

    // Reset with everything requesting: outputs stay 0, and stay idle with run=0.
    clear_inputs();
    reset_n       = 1'b0;
    run           = 1'b1;
    wideband      = 1'b1;
    wb_packets_per_frame = 8'd4;
    cc_ready      = 1'b1;
    mic_ready     = 1'b1;
    sp_data_ready = 1'b1;
    fifo_ready    = '1;
    repeat (3) begin
      @(negedge tx_clock);
      check("reset_outputs",
            32'({grant_valid, grant_src, grant_ddc, port_ID, wb_frame_start, busy}), 32'd0);
    end
    reset_n = 1'b1;
    run     = 1'b0;
    repeat (4) begin
      @(negedge tx_clock);
      check("idle_gv", 32'(grant_valid), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      apply_vec(vecs[i]);
    end

    // Abort in WAIT_DONE of a DDC3 grant; round robin restarts at port 0.
    do_reset();
    apply_vec(mk(0, 0, 4, 0, 0, 0, 'h08, 3, 3, 14, 0));
    run = 1'b0;
    @(negedge tx_clock);
    check("abort_gv", 32'(grant_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_port", 32'(port_ID), 32'd0);
    fifo_ready = 8'h21;
    run = 1'b1;
    @(negedge tx_clock);
    outstanding = 1'b0;
    apply_vec(mk(0, 0, 4, 0, 0, 0, 'h21, 3, 0, 11, 0));

    // pkt_done during GRANT is ignored; pkt_done together with grant_ack is dropped.
    do_reset();
    cc_ready = 1'b1;
    lat = 0;
    wait_gv(lat);
    check("hs_grant", 32'(grant_valid), 32'd1);
    pkt_done = 1'b1;
    @(negedge tx_clock);
    pkt_done = 1'b0;
    check("pkt_done_in_grant", 32'(grant_valid), 32'd1);
    grant_ack = 1'b1;
    pkt_done  = 1'b1;
    @(negedge tx_clock);
    grant_ack = 1'b0;
    pkt_done  = 1'b0;
    check("ack_done_gv", 32'(grant_valid), 32'd0);
    repeat (3) @(negedge tx_clock);
    check("done_dropped_busy", 32'(busy), 32'd1);
    check("done_dropped_gv", 32'(grant_valid), 32'd0);
    outstanding = 1'b1;
    apply_vec(mk(0, 0, 4, 1, 0, 0, 'h00, 0, 0, 1, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
